// File: rtl/sseg_scan_decoder_amisha.sv
// rtl/sseg_scan_decoder_amisha.sv - recovers hex digits from a scanned, active-low 7-segment display bus
module sseg_scan_decoder_amisha #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk_amisha,
    input  logic       reset_amisha,
    input  logic [3:0] an_in_amisha,
    input  logic [7:0] sseg_in_amisha,
    output logic [3:0] hex3_amisha,
    output logic [3:0] hex2_amisha,
    output logic [3:0] hex1_amisha,
    output logic [3:0] hex0_amisha,
    output logic [3:0] dp_out_amisha,
    output logic [3:0] err_amisha,
    output logic [3:0] digit_valid_amisha,
    output logic       frame_valid_amisha
);

    typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [11:0] last_samp, last_nxt;
    logic [3:0]  an_s1, an_s2;
    logic [7:0]  sseg_s1, sseg_s2;
    logic [11:0] samp;
    logic        an_ok, changed, capture;
    logic [1:0]  dig;
    logic [3:0]  dig_bit, mask;
    logic [4:0]  dec;
    logic [3:0]  hex_r [4];

    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'b0000001: decode = 5'h10;
            7'b1001111: decode = 5'h11;
            7'b0010010: decode = 5'h12;
            7'b0000110: decode = 5'h13;
            7'b1001100: decode = 5'h14;
            7'b0100100: decode = 5'h15;
            7'b0100000: decode = 5'h16;
            7'b0001111: decode = 5'h17;
            7'b0000000: decode = 5'h18;
            7'b0000100: decode = 5'h19;
            7'b0001000: decode = 5'h1A;
            7'b1100000: decode = 5'h1B;
            7'b0110001: decode = 5'h1C;
            7'b1000010: decode = 5'h1D;
            7'b0110000: decode = 5'h1E;
            7'b0111000: decode = 5'h1F;
            default:    decode = 5'h00;
        endcase
    endfunction

    always_ff @(posedge clk_amisha) begin
        if (reset_amisha) begin
            an_s1   <= 4'hF;
            an_s2   <= 4'hF;
            sseg_s1 <= 8'hFF;
            sseg_s2 <= 8'hFF;
        end else begin
            an_s1   <= an_in_amisha;
            an_s2   <= an_s1;
            sseg_s1 <= sseg_in_amisha;
            sseg_s2 <= sseg_s1;
        end
    end

    assign samp    = {an_s2, sseg_s2};
    assign changed = (samp != last_samp);
    assign dec     = decode(sseg_s2[6:0]);
    assign dig_bit = 4'b0001 << dig;

    always_comb begin
        an_ok = 1'b1;
        dig   = 2'd0;
        case (an_s2)
            4'b1110: dig = 2'd0;
            4'b1101: dig = 2'd1;
            4'b1011: dig = 2'd2;
            4'b0111: dig = 2'd3;
            default: an_ok = 1'b0;
        endcase
    end

    // cnt counts identical samples seen so far, including the one that started the run.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = last_samp;
        capture   = 1'b0;
        if (!an_ok) begin
            state_nxt = IDLE;
            cnt_nxt   = 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = SETTLE;
                    cnt_nxt   = 8'd1;
                    last_nxt  = samp;
                end
                SETTLE: begin
                    if (changed) begin
                        cnt_nxt  = 8'd1;
                        last_nxt = samp;
                    end else if (cnt + 8'd1 >= STABLE_MAX) begin
                        capture   = 1'b1;
                        state_nxt = HELD;
                        cnt_nxt   = STABLE_MAX;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
                HELD: begin
                    if (changed) begin
                        state_nxt = SETTLE;
                        cnt_nxt   = 8'd1;
                        last_nxt  = samp;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_amisha) begin
        if (reset_amisha) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            last_samp <= 12'hFFF;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            last_samp <= last_nxt;
        end
    end

    always_ff @(posedge clk_amisha) begin
        if (reset_amisha) begin
            for (int i = 0; i < 4; i++) hex_r[i] <= 4'h0;
            dp_out_amisha      <= 4'hF;
            err_amisha         <= 4'h0;
            digit_valid_amisha <= 4'h0;
            frame_valid_amisha <= 1'b0;
            mask               <= 4'h0;
        end else begin
            frame_valid_amisha <= 1'b0;
            if (capture) begin
                if (dec[4]) hex_r[dig] <= dec[3:0];
                dp_out_amisha[dig]      <= sseg_s2[7];
                err_amisha[dig]         <= ~dec[4];
                digit_valid_amisha[dig] <= 1'b1;
                if ((mask | dig_bit) == 4'hF) begin
                    frame_valid_amisha <= 1'b1;
                    mask               <= 4'h0;
                end else begin
                    mask <= mask | dig_bit;
                end
            end
        end
    end

    assign hex0_amisha = hex_r[0];
    assign hex1_amisha = hex_r[1];
    assign hex2_amisha = hex_r[2];
    assign hex3_amisha = hex_r[3];

endmodule

// File: doc/sseg_scan_decoder_amisha.md
SSEG_SCAN_DECODER_AMISHA -- requirements
Module: sseg_scan_decoder_amisha

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, the number of consecutive identical synchronized samples required before a digit is captured; legal range 2..255.
REQ-002 SHALL have port clk_amisha, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_amisha, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port an_in_amisha, input, 4 bits: scanned digit enables, active-low; bit i selects digit i.
REQ-005 SHALL have port sseg_in_amisha, input, 8 bits: segment lines, active-low; [7] is dp, [6:0] is segments a..g (bit 6 = a, bit 0 = g).
REQ-006 SHALL have ports hex3_amisha, hex2_amisha, hex1_amisha and hex0_amisha, outputs, 4 bits each: the decoded nibble of each digit.
REQ-007 SHALL have port dp_out_amisha, output, 4 bits: the captured dp level of each digit, raw active-low.
REQ-008 SHALL have port err_amisha, output, 4 bits: per-digit flag for an unrecognized segment pattern in the latest capture.
REQ-009 SHALL have port digit_valid_amisha, output, 4 bits: sticky flag, digit captured at least once since reset.
REQ-010 SHALL have port frame_valid_amisha, output, 1 bit: one-cycle pulse when all four digits have been captured since the previous pulse.

Function
REQ-011 SHALL pass an_in_amisha and sseg_in_amisha through a 2-flop synchronizer before any other use.
REQ-012 SHALL treat a synchronized an as valid only when exactly one bit is 0.
REQ-013 SHALL implement a scan FSM with states IDLE (an invalid), SETTLE (counting stability) and HELD (captured, waiting for change).
REQ-014 SHALL apply the following transitions: IDLE->SETTLE when a valid an appears; SETTLE->HELD when the sample has been stable for STABLE_CYCLES; HELD->SETTLE or SETTLE->SETTLE (counter cleared) on any change of {an,sseg} to another valid value; any state->IDLE when an becomes invalid.
REQ-015 SHALL, with inputs changing before edge 1 and then held constant, perform the capture exactly at rising edge STABLE_CYCLES+2 (edge 6 for the default) and at no earlier edge.
REQ-016 SHALL perform exactly one capture per HELD entry; while in HELD, no further updates occur.
REQ-017 SHALL decode segment code to nibble as follows: 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9, 0001000=A, 1100000=b, 0110001=C, 1000010=d, 0110000=E, 0111000=F.
REQ-018 SHALL, on a capture of digit i with a recognized code, update hex_i, set dp_out[i] to sseg[7], clear err[i] and set digit_valid[i].
REQ-019 SHALL, on a capture of digit i with an unrecognized code, hold hex_i, update dp_out[i], set err[i], set digit_valid[i] and set the frame mask bit.
REQ-020 SHALL keep an internal 4-bit frame mask and set bit i on each capture of digit i; recapturing the same digit within a frame leaves the mask unchanged.
REQ-021 SHALL, when a capture makes the mask 1111, assert frame_valid_amisha for the next cycle only and clear the mask at that same edge.
REQ-022 SHALL leave the mask and all outputs unchanged on an invalid an (blank or multiple digits); only the FSM state and counter are affected.
REQ-023 SHALL saturate the stability counter at STABLE_CYCLES so that it never wraps.

Reset
REQ-024 SHALL, while reset_amisha is high at a rising edge, set hex0-3 to 0, dp_out to 1111, err to 0000, digit_valid to 0000, frame_valid to 0, mask to 0000, counter to 0, FSM to IDLE, synchronizer an stages to 1111 and synchronizer sseg stages to 11111111.
REQ-025 SHALL, on reset asserted mid-SETTLE, perform no capture, and capture timing SHALL restart per REQ-015 after reset deasserts.

Verification
REQ-026 SHALL verify: an=1110, sseg=0_0100100 held for 10 cycles -> hex0=5, dp_out[0]=0, err[0]=0, digit_valid=0001 at edge 6, with no change at edges 7-10.
REQ-027 SHALL verify: digits 0..3 driven with codes 1,2,3,4 (an 1110,1101,1011,0111), each held 8 cycles -> hex3..0=4,3,2,1, and frame_valid pulses exactly once, one cycle after the digit-3 capture.
REQ-028 SHALL verify: an=1101 with code 7 held for only 3 cycles, then an=1111 -> hex1 unchanged, digit_valid[1]=0.
REQ-029 SHALL verify: digit 2 driven with 1111111 for 8 cycles -> err[2]=1 and hex2 holds its prior value; then code 8 -> err[2]=0, hex2=8.
REQ-030 SHALL verify: an=1100 held for 20 cycles -> no capture and all outputs unchanged.
REQ-031 SHALL verify: reset pulsed at cycle 3 of a digit-0 settle -> no capture, all outputs at reset values, and capture occurs at edge 6 after release.
